// File: rtl/seq_alu.sv
// Clocked ALU with registered result and Z/S/C/V flags.
// Shifts and unsigned multiply run iteratively under a START/BUSY/DONE handshake.
module seq_alu #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       SSEL,
  output logic [WIDTH-1:0] F,
  output logic             Z,
  output logic             S,
  output logic             C,
  output logic             V,
  output logic             BUSY,
  output logic             DONE
);

  localparam int unsigned SW = WIDTH + 1;
  localparam int unsigned AW = 2 * WIDTH;
  localparam int unsigned CW = SHW + 1;

  localparam logic [3:0] OP_TRA = 4'b0000;
  localparam logic [3:0] OP_INC = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_ADC = 4'b0011;
  localparam logic [3:0] OP_SHL = 4'b0100;
  localparam logic [3:0] OP_SUB = 4'b0101;
  localparam logic [3:0] OP_DEC = 4'b0110;
  localparam logic [3:0] OP_TRC = 4'b0111;
  localparam logic [3:0] OP_AND = 4'b1000;
  localparam logic [3:0] OP_SHR = 4'b1001;
  localparam logic [3:0] OP_OR  = 4'b1010;
  localparam logic [3:0] OP_ASR = 4'b1011;
  localparam logic [3:0] OP_XOR = 4'b1100;
  localparam logic [3:0] OP_MUL = 4'b1101;
  localparam logic [3:0] OP_NOT = 4'b1110;
  localparam logic [3:0] OP_RSV = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_MULT
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [3:0]       op_q;
  logic             pend;
  logic [CW-1:0]    cnt;
  logic [AW-1:0]    acc;

  logic [SW-1:0]    sum;
  logic [WIDTH-1:0] alu_f;
  logic             alu_c;
  logic             alu_v;
  logic             alu_z;

  // Single-cycle datapath on the latched operands; ADC reads the live C flag
  always_comb begin
    sum   = '0;
    alu_f = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (op_q)
      OP_TRA, OP_TRC, OP_SHL, OP_SHR, OP_ASR: alu_f = a_q;
      OP_INC: begin
        sum   = {1'b0, a_q} + SW'(1);
        alu_f = sum[WIDTH-1:0];
        alu_c = sum[WIDTH];
        alu_v = ~a_q[WIDTH-1] & alu_f[WIDTH-1];
      end
      OP_ADD, OP_ADC: begin
        sum   = {1'b0, a_q} + {1'b0, b_q} + ((op_q == OP_ADC) ? SW'(C) : SW'(0));
        alu_f = sum[WIDTH-1:0];
        alu_c = sum[WIDTH];
        alu_v = ~(a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (alu_f[WIDTH-1] ^ a_q[WIDTH-1]);
      end
      OP_SUB: begin
        sum   = {1'b0, a_q} - {1'b0, b_q};
        alu_f = sum[WIDTH-1:0];
        alu_c = sum[WIDTH];
        alu_v = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (alu_f[WIDTH-1] ^ a_q[WIDTH-1]);
      end
      OP_DEC: begin
        sum   = {1'b0, a_q} - SW'(1);
        alu_f = sum[WIDTH-1:0];
        alu_c = sum[WIDTH];
        alu_v = a_q[WIDTH-1] & ~alu_f[WIDTH-1];
      end
      OP_AND: alu_f = a_q & b_q;
      OP_OR:  alu_f = a_q | b_q;
      OP_XOR: alu_f = a_q ^ b_q;
      OP_NOT: alu_f = ~a_q;
      default: alu_f = '0;
    endcase
    alu_z = (alu_f == '0) && (op_q != OP_RSV);
  end

  logic [AW-1:0] step_acc;
  logic          step_c;
  logic [SW-1:0] part;

  // One iteration: shift one bit in the low half, or one shift-add multiply step
  always_comb begin
    step_acc = acc;
    step_c   = 1'b0;
    part     = '0;
    if (state == ST_MULT) begin
      part     = {1'b0, acc[AW-1:WIDTH]} + (acc[0] ? {1'b0, a_q} : SW'(0));
      step_acc = {part, acc[WIDTH-1:1]};
      step_c   = |step_acc[AW-1:WIDTH];
    end else begin
      case (op_q)
        OP_SHL: begin
          step_acc = {acc[AW-1:WIDTH], acc[WIDTH-2:0], 1'b0};
          step_c   = acc[WIDTH-1];
        end
        OP_SHR: begin
          step_acc = {acc[AW-1:WIDTH], 1'b0, acc[WIDTH-1:1]};
          step_c   = acc[0];
        end
        OP_ASR: begin
          step_acc = {acc[AW-1:WIDTH], acc[WIDTH-1], acc[WIDTH-1:1]};
          step_c   = acc[0];
        end
        default: step_c = 1'b0;
      endcase
    end
  end

  logic shift_req;
  assign shift_req = ((SSEL == OP_SHL) || (SSEL == OP_SHR) || (SSEL == OP_ASR))
                     && (B[SHW-1:0] != '0);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_IDLE;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
      pend  <= 1'b0;
      cnt   <= '0;
      acc   <= '0;
      F     <= '0;
      Z     <= 1'b0;
      S     <= 1'b0;
      C     <= 1'b0;
      V     <= 1'b0;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        ST_IDLE: begin
          BUSY <= 1'b0;
          pend <= 1'b0;
          if (pend) begin
            F    <= alu_f;
            Z    <= alu_z;
            S    <= alu_f[WIDTH-1];
            C    <= alu_c;
            V    <= alu_v;
            DONE <= 1'b1;
          end
          if (START) begin
            a_q  <= A;
            b_q  <= B;
            op_q <= SSEL;
            if (shift_req) begin
              state <= ST_SHIFT;
              cnt   <= CW'(B[SHW-1:0]);
              acc   <= {{WIDTH{1'b0}}, A};
            end else if (SSEL == OP_MUL) begin
              state <= ST_MULT;
              cnt   <= CW'(WIDTH);
              acc   <= {{WIDTH{1'b0}}, B};
            end else begin
              pend <= 1'b1;
            end
          end
        end
        ST_SHIFT, ST_MULT: begin
          acc <= step_acc;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state <= ST_IDLE;
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
            F     <= step_acc[WIDTH-1:0];
            Z     <= (step_acc[WIDTH-1:0] == '0);
            S     <= step_acc[WIDTH-1];
            C     <= step_c;
            V     <= 1'b0;
          end else begin
            BUSY <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
